// File: rtl/boot_ctrl.sv
// boot_ctrl: boot sequencer and memory write-port arbiter.
//
// Holds the CPU in reset while a UART upload streams bytes in, packs those
// bytes into 32-bit word writes with byte strobes, flushes any partial word
// when the upload ends, then hands the memory write port to the CPU.
// A start pulse while running re-enters the boot sequence.
//
// Optional feature: define BOOT_CTRL_TIMEOUT_EN to build the inter-byte
// upload timeout (sticky error flag, forced flush). Without it, error is 0
// and LOAD waits indefinitely for ld_complete.
//
// Ports:
//   clk, reset (sync, active-high), clk_enable (global advance enable)
//   start                       reload request, honoured in RUN only
//   ld_we/ld_addr/ld_byte       uploaded byte stream
//   ld_complete                 upload finished (level)
//   ld_reset, cpu_reset         resets for the upload receiver and the CPU
//   cpu_mem_we/addr/wdata/wstrb CPU write request
//   cpu_mem_stall               CPU must hold its request
//   mem_we/addr/wdata/wstrb     memory write port (addr word-aligned)
//   state                       current state (debug)
//   error                       sticky upload-timeout flag
module boot_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 25175000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_byte,
  input  logic        ld_complete,
  output logic        ld_reset,
  output logic        cpu_reset,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_stall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [1:0]  state,
  output logic        error
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    LOAD  = 2'b01,
    FLUSH = 2'b10,
    RUN   = 2'b11
  } state_t;

  state_t      state_q, state_d;

  // Pack buffer: word address, lane data and lane-valid mask.
  logic [29:0] buf_word_q, buf_word_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [3:0]  buf_mask_q, buf_mask_d;

  // Registered loader-side write port.
  logic        wr_we_q,   wr_we_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_strb_q, wr_strb_d;

  logic [1:0]  lane;
  assign lane = ld_addr[1:0];

`ifdef BOOT_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;   // first byte of this upload seen
  logic             error_q, error_d;

  logic unused_bits;
  assign unused_bits = ^cpu_mem_addr[1:0];
`else
  // Low CPU address bits are dropped by word alignment.
  logic unused_bits;
  assign unused_bits = ^{cpu_mem_addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

  // NOTE: reset is synchronous and wins over clk_enable; clk_enable=0 freezes
  // every register, including the one-cycle loader write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      buf_word_q <= '0;
      buf_data_q <= '0;
      buf_mask_q <= '0;
      wr_we_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
`ifdef BOOT_CTRL_TIMEOUT_EN
      cnt_q      <= '0;
      started_q  <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else if (clk_enable) begin
      state_q    <= state_d;
      buf_word_q <= buf_word_d;
      buf_data_q <= buf_data_d;
      buf_mask_q <= buf_mask_d;
      wr_we_q    <= wr_we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
`ifdef BOOT_CTRL_TIMEOUT_EN
      cnt_q      <= cnt_d;
      started_q  <= started_d;
      error_q    <= error_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    buf_word_d = buf_word_q;
    buf_data_d = buf_data_q;
    buf_mask_d = buf_mask_q;
    wr_we_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
`ifdef BOOT_CTRL_TIMEOUT_EN
    cnt_d      = cnt_q;
    started_d  = started_q;
    error_d    = error_q;
`endif

    unique case (state_q)
      BOOT: begin
        buf_word_d = '0;
        buf_data_d = '0;
        buf_mask_d = '0;
`ifdef BOOT_CTRL_TIMEOUT_EN
        cnt_d      = '0;
        started_d  = 1'b0;
        error_d    = 1'b0;
`endif
        state_d    = LOAD;
      end

      LOAD: begin
        if (ld_we) begin
          // A byte for another word evicts the current partial word.
          if (buf_mask_q != 4'b0000 && ld_addr[31:2] != buf_word_q) begin
            wr_we_d    = 1'b1;
            wr_addr_d  = {buf_word_q, 2'b00};
            wr_data_d  = buf_data_q;
            wr_strb_d  = buf_mask_q;
            buf_data_d = '0;
            buf_mask_d = '0;
          end
          if (buf_mask_d == 4'b0000) begin
            buf_word_d = ld_addr[31:2];
          end
          buf_data_d[{lane, 3'b000} +: 8] = ld_byte;
          buf_mask_d[lane]                = 1'b1;
          // Only a merge can fill the word; a fresh load sets one lane.
          if (buf_mask_d == 4'b1111) begin
            wr_we_d    = 1'b1;
            wr_addr_d  = {buf_word_d, 2'b00};
            wr_data_d  = buf_data_d;
            wr_strb_d  = 4'b1111;
            buf_data_d = '0;
            buf_mask_d = '0;
          end
        end
`ifdef BOOT_CTRL_TIMEOUT_EN
        if (ld_we) begin
          cnt_d     = '0;
          started_d = 1'b1;
        end else if (started_q) begin
          if (cnt_q == CNT_LAST) begin
            error_d = 1'b1;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (ld_complete) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (buf_mask_q != 4'b0000) begin
          wr_we_d    = 1'b1;
          wr_addr_d  = {buf_word_q, 2'b00};
          wr_data_d  = buf_data_q;
          wr_strb_d  = buf_mask_q;
          buf_data_d = '0;
          buf_mask_d = '0;
        end
        state_d = RUN;
      end

      RUN: begin
        if (start) begin
          state_d = BOOT;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  assign state         = state_q;
  assign ld_reset      = (state_q == BOOT);
  assign cpu_reset     = (state_q != RUN);
  assign cpu_mem_stall = (state_q != RUN);

`ifdef BOOT_CTRL_TIMEOUT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // The flush write is registered, so it lands in the first RUN cycle; the
  // CPU has only just left reset then and cannot yet issue a store, so the
  // loader write takes that cycle and the CPU owns the port afterwards.
  always_comb begin
    if (wr_we_q || state_q != RUN) begin
      mem_we    = wr_we_q;
      mem_addr  = wr_addr_q;
      mem_wdata = wr_data_q;
      mem_wstrb = wr_strb_q;
    end else begin
      mem_we    = cpu_mem_we;
      mem_addr  = {cpu_mem_addr[31:2], 2'b00};
      mem_wdata = cpu_mem_wdata;
      mem_wstrb = cpu_mem_wstrb;
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Self-checking bench for boot_ctrl: a byte-stream reference model feeds an
// expected-write queue; a monitor pops and compares on every memory write.
module tb_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic        ld_we, ld_complete;
  logic [31:0] ld_addr;
  logic [7:0]  ld_byte;
  logic        ld_reset, cpu_reset;
  logic        cpu_mem_we;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_stall;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  state;
  logic        error;

  boot_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_complete(ld_complete), .ld_reset(ld_reset), .cpu_reset(cpu_reset),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_stall(cpu_mem_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .state(state), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
  } byte_t;

  wr_t   exp_q[$];
  byte_t pend_q[$];   // bytes of the word currently being assembled, in order

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes accumulate until the word address changes, all four lanes have
  // been seen, or the upload ends; each such group becomes one write whose
  // lanes hold the last byte written to them.
  function automatic void model_emit();
    wr_t w;
    int  lane;
    w.addr = {pend_q[0].addr[31:2], 2'b00};
    w.data = '0;
    w.strb = '0;
    foreach (pend_q[i]) begin
      lane = int'(pend_q[i].addr[1:0]);
      w.data[lane*8 +: 8] = pend_q[i].b;
      w.strb[lane]        = 1'b1;
    end
    exp_q.push_back(w);
    pend_q.delete();
  endfunction

  function automatic void model_byte(input logic [31:0] a, input logic [7:0] b);
    logic [3:0] seen;
    byte_t      nb;
    if (pend_q.size() > 0 && pend_q[0].addr[31:2] != a[31:2]) model_emit();
    nb.addr = a;
    nb.b    = b;
    pend_q.push_back(nb);
    seen = '0;
    foreach (pend_q[i]) seen[pend_q[i].addr[1:0]] = 1'b1;
    if (seen == 4'b1111) model_emit();
  endfunction

  function automatic void model_flush();
    if (pend_q.size() > 0) model_emit();
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && clk_enable === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {mem_addr, 28'd0, mem_wstrb}, 64'd0);
      end else begin
        wr_t        e;
        logic [31:0] m;
        e = exp_q.pop_front();
        m = {{8{e.strb[3]}}, {8{e.strb[2]}}, {8{e.strb[1]}}, {8{e.strb[0]}}};
        check("wr_addr", mem_addr, e.addr);
        check("wr_strb", mem_wstrb, e.strb);
        check("wr_data", mem_wdata & m, e.data & m);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    clk_enable = 1'b0;   // reset must win over a gated clock
    tick();
    reset      = 1'b0;
    clk_enable = 1'b1;
    pend_q.delete();
    check("rst_state", state, 2'b00);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_ld_reset", ld_reset, 1'b1);
    check("rst_stall", cpu_mem_stall, 1'b1);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_error", error, 1'b0);
  endtask

  task automatic enter_load();
    reset_dut();
    tick();
    check("load_state", state, 2'b01);
    check("load_ld_reset", ld_reset, 1'b0);
  endtask

  task automatic send_byte(input logic [31:0] a, input logic [7:0] b, input bit complete);
    clk_enable  = 1'b1;
    ld_we       = 1'b1;
    ld_addr     = a;
    ld_byte     = b;
    ld_complete = complete;
    model_byte(a, b);
    if (complete) model_flush();
    tick();
    ld_we       = 1'b0;
    ld_complete = 1'b0;
  endtask

  task automatic idle(input int n, input bit gate);
    int  k = 0;
    bit  en;
    while (k < n) begin
      en = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
      clk_enable = en;
      tick();
      if (en) k++;
    end
    clk_enable = 1'b1;
  endtask

  // Finish the upload and follow the two enabled cycles to RUN.
  task automatic complete_upload(input bit with_byte, input logic [31:0] a, input logic [7:0] b);
    if (with_byte) begin
      send_byte(a, b, 1'b1);
    end else begin
      ld_complete = 1'b1;
      model_flush();
      tick();
      ld_complete = 1'b0;
    end
    check("flush_state", state, 2'b10);
    check("flush_cpu_reset", cpu_reset, 1'b1);
    tick();
    check("run_state", state, 2'b11);
    check("run_cpu_reset", cpu_reset, 1'b0);
    check("run_stall", cpu_mem_stall, 1'b0);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = {a[31:2], 2'b00};
    w.data = d;
    w.strb = s;
    exp_q.push_back(w);
    cpu_mem_we    = 1'b1;
    cpu_mem_addr  = a;
    cpu_mem_wdata = d;
    cpu_mem_wstrb = s;
    #1;
    check("cpu_pass_we", mem_we, 1'b1);
    check("cpu_pass_addr", mem_addr, w.addr);
    check("cpu_pass_strb", mem_wstrb, s);
    check("cpu_pass_stall", cpu_mem_stall, 1'b0);
    tick();
    cpu_mem_we = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_byte = '0; ld_complete = 1'b0;
    cpu_mem_we = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
    tick();

    // Full word at 0, then completion.
    enter_load();
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", mem_wstrb, 4'd0);
    send_byte(32'd0, 8'h11, 1'b0);
    send_byte(32'd1, 8'h22, 1'b0);
    send_byte(32'd2, 8'h33, 1'b0);
    check("no_early_write", mem_we, 1'b0);
    send_byte(32'd3, 8'h44, 1'b0);
    check("full_word_latency", mem_we, 1'b1);
    complete_upload(1'b0, '0, '0);

    // Eviction on word change, then flush of the partial word.
    enter_load();
    send_byte(32'd5, 8'hAA, 1'b0);
    send_byte(32'd12, 8'hBB, 1'b0);
    check("evict_latency", mem_we, 1'b1);
    complete_upload(1'b0, '0, '0);

    // CPU owns the port in RUN.
    tick();
    cpu_write(32'h102, 32'hDEADBEEF, 4'b1100);
    for (int i = 0; i < 6; i++) begin
      cpu_write($urandom, $urandom, 4'($urandom_range(1, 15)));
    end

    // start re-enters BOOT; CPU requests are blocked in LOAD.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", state, 2'b00);
    check("start_cpu_reset", cpu_reset, 1'b1);
    check("start_error", error, 1'b0);
    tick();
    check("reload_state", state, 2'b01);
    cpu_mem_we = 1'b1; cpu_mem_addr = 32'h102; cpu_mem_wdata = 32'hDEADBEEF; cpu_mem_wstrb = 4'b1100;
    #1;
    check("load_cpu_we_blocked", mem_we, 1'b0);
    check("load_cpu_stall", cpu_mem_stall, 1'b1);
    tick();
    cpu_mem_we = 1'b0;

    // Reset mid-word discards the buffered bytes.
    send_byte(32'h20, 8'h01, 1'b0);
    send_byte(32'h21, 8'h02, 1'b0);
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_no_write", mem_we, 1'b0);
    end

    // Randomized upload with gated idle cycles; ends with a merged byte.
    enter_load();
    for (int i = 0; i < 40; i++) begin
      send_byte(32'h400 + 32'($urandom_range(0, 15)), 8'($urandom), 1'b0);
      idle($urandom_range(0, 2), 1'b1);
    end
`ifndef BOOT_CTRL_TIMEOUT_EN
    idle(20, 1'b1);
    check("no_timeout_state", state, 2'b01);
    check("no_timeout_error", error, 1'b0);
`endif
    complete_upload(1'b1, 32'h40D, 8'hC3);
    tick();

`ifdef BOOT_CTRL_TIMEOUT_EN
    // One byte then silence; gated cycles must not count.
    enter_load();
    send_byte(32'd3, 8'h5A, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      clk_enable = 1'b0;
      tick();
      clk_enable = 1'b1;
      tick();
      if (k < 16) begin
        check("timeout_wait_state", state, 2'b01);
        check("timeout_wait_error", error, 1'b0);
      end
    end
    check("timeout_state", state, 2'b10);
    check("timeout_error", error, 1'b1);
    model_flush();
    tick();
    check("timeout_run", state, 2'b11);
    check("timeout_error_sticky", error, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("timeout_boot_clear", error, 1'b0);
    tick();
`endif

    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot sequencer and memory-port arbiter between the UART upload receiver and the CPU. It holds the CPU in reset and drives the upload receiver's reset. It packs uploaded bytes into 32-bit word writes with byte strobes. After the upload completes it flushes any partial word, then hands the memory write port to the CPU. A `start` pulse in RUN re-enters the boot sequence for a fresh upload.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 25175000: idle cycles (with `clk_enable`=1) tolerated between uploaded bytes once loading has begun.

Ports:
- `clk` in 1: system clock; only clock.
- `reset` in 1: synchronous, active-high; overrides `clk_enable`.
- `clk_enable` in 1: all registers advance only when 1.
- `start` in 1: reload request; honoured only in RUN.
- `ld_we` in 1: byte-valid pulse from the upload receiver.
- `ld_addr` in 32: byte address of `ld_byte`.
- `ld_byte` in 8: uploaded byte.
- `ld_complete` in 1: upload finished (level).
- `ld_reset` out 1: reset to the upload receiver.
- `cpu_reset` out 1: reset to the CPU.
- `cpu_mem_we` in 1: CPU write request.
- `cpu_mem_addr` in 32: CPU byte address.
- `cpu_mem_wdata` in 32: CPU write data.
- `cpu_mem_wstrb` in 4: CPU byte strobes.
- `cpu_mem_stall` out 1: CPU must hold its request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned byte address; bits [1:0] are always 0.
- `mem_wdata` out 32: memory write data.
- `mem_wstrb` out 4: memory byte strobes.
- `state` out 2: current state, for debug.
- `error` out 1: sticky upload-timeout flag.

## Operation
States and encodings: BOOT=00, LOAD=01, FLUSH=10, RUN=11.

Reset values:
- State BOOT.
- `cpu_reset`=1, `ld_reset`=1, `cpu_mem_stall`=1.
- Loader-side `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
- `error`=0.
- Pack buffer empty (mask 0), timeout counter 0.

BOOT:
- `ld_reset`=1, buffer cleared, `error` cleared.
- Goes to LOAD on the next enabled cycle.

LOAD:
- `ld_reset`=0.
- On each `ld_we`, byte lane = `ld_addr[1:0]`, word = `ld_addr[31:2]`.
  - Buffer empty: latch the word address, write the byte into its lane, set that mask bit.
  - Same word: merge the byte; a rewritten lane is overwritten.
  - Different word: emit the old buffer as a write and reload the buffer with the new byte, in the same cycle.
- When the mask becomes 4'b1111, emit the write and empty the buffer. Emitted strobes equal the mask.
- `ld_complete`=1 goes to FLUSH. If `ld_we` is also 1 that cycle, the byte is merged first.

FLUSH:
- If the mask is non-zero, emit one write of the partial word; then go to RUN.
- An empty buffer goes directly to RUN, with no write.

RUN:
- `cpu_reset`=0, `cpu_mem_stall`=0.
- `mem_*` is a combinational passthrough of the `cpu_mem_*` inputs, with `mem_addr`[1:0] forced to 0.
- `start`=1 goes to BOOT; the CPU is back in reset on the following cycle.

All other states:
- `cpu_mem_stall`=1 and `cpu_reset`=1.
- CPU requests are ignored and never reach memory.

## Timing
- Loader writes are registered: `mem_we` asserts exactly one enabled cycle after the `ld_we` that completes or evicts a word. It is held only for that cycle.
- `cpu_mem_stall`, `cpu_reset` and `ld_reset` decode combinationally from `state`.
- Reset → RUN takes at least 3 enabled cycles (BOOT, LOAD, FLUSH).
- `ld_complete` → `cpu_reset`=0 takes 2 enabled cycles (LOAD→FLUSH, FLUSH→RUN).
- `clk_enable`=0 freezes state, buffer, counter and registered outputs.
- `reset` mid-LOAD discards the buffered partial word; no write is issued.

## Configuration
`BOOT_CTRL_TIMEOUT_EN` defined:
- In LOAD, the counter clears on every `ld_we` and increments only after the first byte has arrived.
- On reaching `TIMEOUT_CYCLES`, set `error`=1 and go to FLUSH. The partial word is still written.
- `error` stays set until `reset` or BOOT.

`BOOT_CTRL_TIMEOUT_EN` undefined:
- No counter is built; `error` is tied to 0.
- LOAD waits indefinitely for `ld_complete`.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 at addresses 0–3, then `ld_complete` → one write: `mem_addr`=0, `mem_wdata`=0x44332211, `mem_wstrb`=4'b1111. `cpu_reset` falls 2 cycles after `ld_complete`.
- Bytes 0xAA at addr 5, then 0xBB at addr 12 → write addr 4, wstrb 4'b0010, data[15:8]=0xAA. `ld_complete` then flushes addr 12, wstrb 4'b0001, data[7:0]=0xBB.
- In RUN, CPU writes 0xDEADBEEF to addr 0x102 with wstrb 4'b1100 → same-cycle `mem_we`=1, `mem_addr`=0x100, `mem_wstrb`=4'b1100, `cpu_mem_stall`=0. In LOAD, the same request → `mem_we`=0, `cpu_mem_stall`=1.
- `reset` asserted after 2 of 4 bytes → no `mem_we` ever, state=00, `ld_reset`=1. A `start` pulse in RUN → BOOT, `cpu_reset`=1, `error` cleared.
- With `BOOT_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: one byte 0x5A at addr 3, then silence → after 16 enabled cycles `error`=1, a write at addr 0 with wstrb 4'b1000, then RUN. Toggling `clk_enable` low during the wait stretches the timeout by the gated cycles.
